// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial adder/subtractor. Two WIDTH-bit operands are
//               accepted over a valid/ready handshake and then summed one bit
//               per clock, LSB first, through a single full-adder cell with a
//               registered carry. The WIDTH-bit result and carry-out are
//               presented over a second valid/ready handshake.
//
// Parameters  : WIDTH      operand/result width in bits, legal range 1..64
//
// Ports       : clk        rising-edge clock
//               rst_n      asynchronous active-low reset
//               in_valid   operands/mode valid
//               in_ready   block can accept operands (IDLE only)
//               a, b       operands
//               cin        carry-in for add; ignored when sub=1
//               sub        0: a+b+cin, 1: a-b (as a+~b+1)
//               out_valid  result valid (DONE only)
//               out_ready  downstream accepts result
//               sum        result, modulo 2^WIDTH
//               cout       carry out of bit WIDTH-1; for sub, 1 = no borrow
//               busy       high while bits are being processed
//               ovf        (SERIAL_ADDER_OVF_EN only) signed overflow flag
//
// Options     : `define SERIAL_ADDER_OVF_EN to add the ovf output.
//
// Revision    : 1.0  initial release
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // One spare counter bit so the count never wraps inside an operation, even
  // when WIDTH is a power of two.
  localparam int                 c_cnt_w    = $clog2(WIDTH) + 1;
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  // --------------------------------------------------------------------------
  // State machine encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]   r_a_sh;     // operand A, consumed from bit 0
  logic [WIDTH-1:0]   r_b_sh;     // operand B (already inverted for sub)
  logic [WIDTH-1:0]   r_res;      // partial result, filled from the MSB end
  logic               r_carry;    // carry into the bit currently processed
  logic [c_cnt_w-1:0] r_cnt;      // index of the bit currently processed
  logic [WIDTH-1:0]   r_sum;      // published result
  logic               r_cout;     // published carry-out

  // --------------------------------------------------------------------------
  // Combinational wires
  // --------------------------------------------------------------------------
  logic             w_accept;     // operand handshake completes this edge
  logic             w_step;       // one bit is processed this edge
  logic             w_last;       // this edge processes the final bit
  logic             w_s;          // full-adder sum bit
  logic             w_maj;        // full-adder carry out
  logic [WIDTH-1:0] w_res_nxt;    // partial result after this bit

  // --------------------------------------------------------------------------
  // One-bit full-adder cell
  // --------------------------------------------------------------------------
  assign w_s   = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
  assign w_maj = (r_a_sh[0] & r_b_sh[0]) |
                 (r_a_sh[0] & r_carry)   |
                 (r_b_sh[0] & r_carry);

  // The new bit enters at the MSB; after WIDTH steps bit 0 of the operands
  // has travelled down to bit 0 of the result. Written as shift/OR rather
  // than a part-select so the same expression is legal for WIDTH=1.
  assign w_res_nxt = (r_res >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;

    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end

      S_RUN: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (r_cnt == c_last_cnt) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        // Returning to IDLE only; a new operand cannot be taken on the same
        // edge as the result handshake.
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  // Subtraction is folded into the add path: B is inverted at load time and
  // the initial carry forced to 1, giving a + ~b + 1. The result registers
  // are only written on the final step so sum/cout stay frozen through
  // RUN, DONE and the following IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= sub ? ~b : b;
      r_carry <= sub ? 1'b1 : cin;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_a_sh  <= r_a_sh >> 1;
      r_b_sh  <= r_b_sh >> 1;
      r_res   <= w_res_nxt;
      r_carry <= w_maj;
      r_cnt   <= r_cnt + c_cnt_one;
      if (w_last) begin
        r_sum  <= w_res_nxt;
        r_cout <= w_maj;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

`ifdef SERIAL_ADDER_OVF_EN
  // --------------------------------------------------------------------------
  // Signed overflow: on the final step r_carry is the carry into the MSB and
  // w_maj the carry out of it; they differ exactly when the two's-complement
  // result does not fit in WIDTH bits.
  // --------------------------------------------------------------------------
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= r_carry ^ w_maj;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire
